demux2_stream: RTL and testbench
================================

Name: demux2_stream

Overview:
- Registered 1-to-2 stream demultiplexer; the steering counterpart of mux2.
- Takes one valid/ready source and routes each accepted word to sink 0 or sink 1 according to i_sel.
- Each sink has one output register stage with independent backpressure, plus a per-sink transfer counter.
- Used on the processor side to fan a single result/write stream out to two consumers, e.g. register-file write-back vs. memory/peripheral path.

Parameters:
P_WIDTH, 32, data width of source and both sinks
P_CNT_WIDTH, 8, width of per-sink accepted-transfer counters

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous reset, active-low
i_data  input  P_WIDTH  source data
i_valid  input  1  source data valid
i_sel  input  1  destination select (0 = sink 0, 1 = sink 1), sampled with i_data
o_ready  output  1  source may transfer this cycle
o_d0  output  P_WIDTH  sink 0 data
o_valid0  output  1  sink 0 data valid
i_ready0  input  1  sink 0 accepts
o_d1  output  P_WIDTH  sink 1 data
o_valid1  output  1  sink 1 data valid
i_ready1  input  1  sink 1 accepts
i_clr  input  1  synchronous clear of both counters
o_cnt0  output  P_CNT_WIDTH  words delivered into sink 0 stage
o_cnt1  output  P_CNT_WIDTH  words delivered into sink 1 stage

Behaviour:

Reset (i_rst_n low, asynchronous):
- o_valid0 = o_valid1 = 0, o_d0 = o_d1 = 0, o_cnt0 = o_cnt1 = 0.
- o_ready follows its combinational equation (ready for any select, since both stages are empty).

Per sink k, the output stage is either EMPTY (o_validk = 0) or FULL (o_validk = 1).

Handshake:
- o_ready = ~o_valid[i_sel] | i_ready[i_sel].
  - Combinational from i_sel, stage state and the selected sink's ready only.
  - Never depends on i_valid.
- Accept = i_valid & o_ready.
- On accept, at the next edge: o_d[i_sel] <= i_data, o_valid[i_sel] <= 1, o_cnt[i_sel] increments.
- Sink k drains when o_validk & i_readyk.
  - If not refilled in the same cycle, o_validk <= 0 at the next edge.
  - o_dk holds its last value; it is not cleared.
- Same-cycle drain and refill of the same sink: o_validk stays 1 and o_dk takes the new word (full throughput, 1 word/cycle).
- Latency: accepted word appears on the sink outputs 1 cycle after the accept edge.
- Unselected sink: unaffected by the source; it may drain in the same cycle another word goes to the other sink.
- Stalled sink k: o_validk and o_dk stay stable until i_readyk is high.
- Source stall: o_ready low for the selected sink means no accept. The source must hold i_data/i_sel/i_valid; the block does not check this.
- i_valid low: no state change except drains.

Counters:
- Count accepts per sink, not sink-side drains.
- Wrap modulo 2^P_CNT_WIDTH (max value + 1 -> 0).
- i_clr has priority over an increment in the same cycle; the result is 0 for both counters.
- i_clr does not affect data or valid state.

Asynchronous reset mid-transfer:
- Any in-flight word is discarded immediately.
- Valids and counters go to 0 regardless of the clock.

Test Plan:
1. Reset, then i_sel=0, i_data=32'hAAAAAAAA, i_valid=1, i_ready0=1 for one cycle -> next cycle o_valid0=1, o_d0=AAAAAAAA, o_valid1=0, o_cnt0=1, o_cnt1=0.
2. Backpressure: i_ready1=0; send 32'h55555555 to sink 1, then hold 32'h12345678 with i_sel=1 -> o_ready=0, o_d1 stays 55555555 for the whole stall. Raise i_ready1 -> next cycle o_d1=12345678, o_cnt1=2.
3. Cross-steer during stall: sink 1 stalled full, source presents i_sel=0, 32'h87654321 -> o_ready=1, word lands in sink 0 the next cycle, sink 1 unchanged.
4. Streaming: both readies high, 16 consecutive words alternating select, data = index -> 1 word/cycle, no bubbles; each sink sees its words in order; o_cnt0=8, o_cnt1=8.
5. Wrap and clear: P_CNT_WIDTH=8, send 256 words to sink 0 -> o_cnt0=0. Then assert i_clr together with an accept -> both counters 0 the next cycle.
6. Async reset while o_valid1=1 with i_ready1=0 and counters nonzero: drop i_rst_n between clock edges -> o_valid1, o_cnt0 and o_cnt1 become 0 immediately. After release, first accept resumes normally.

Source files
------------

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer.
// Each accepted source word is steered by i_sel into the output register of
// sink 0 or sink 1. Each sink stage drains independently under its own ready,
// and a per-sink counter tallies the words delivered into that stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds its data and valid stable while valid is high and
// ready is low. The ready output never depends on the matching valid input.
// On the source side, o_ready depends only on i_sel, the selected stage's
// occupancy and that sink's ready, so a full stage that drains this cycle can
// accept a refill in the same cycle.
module demux2_stream #(
  parameter int P_WIDTH     = 32,
  parameter int P_CNT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [P_WIDTH-1:0]     i_data,
  input  logic                   i_valid,
  input  logic                   i_sel,
  output logic                   o_ready,
  output logic [P_WIDTH-1:0]     o_d0,
  output logic                   o_valid0,
  input  logic                   i_ready0,
  output logic [P_WIDTH-1:0]     o_d1,
  output logic                   o_valid1,
  input  logic                   i_ready1,
  input  logic                   i_clr,
  output logic [P_CNT_WIDTH-1:0] o_cnt0,
  output logic [P_CNT_WIDTH-1:0] o_cnt1
);

  logic accept;
  logic acc0;
  logic acc1;

  // The selected stage can take a word when it is empty or is being drained now
  assign o_ready = i_sel ? (~o_valid1 | i_ready1) : (~o_valid0 | i_ready0);
  assign accept  = i_valid & o_ready;
  assign acc0    = accept & ~i_sel;
  assign acc1    = accept &  i_sel;

  // Sink 0 stage: refill on accept, otherwise drop valid once drained; data holds
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid0 <= 1'b0;
      o_d0     <= '0;
    end else if (acc0) begin
      o_valid0 <= 1'b1;
      o_d0     <= i_data;
    end else if (o_valid0 && i_ready0) begin
      o_valid0 <= 1'b0;
    end
  end

  // Sink 1 stage: refill on accept, otherwise drop valid once drained; data holds
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid1 <= 1'b0;
      o_d1     <= '0;
    end else if (acc1) begin
      o_valid1 <= 1'b1;
      o_d1     <= i_data;
    end else if (o_valid1 && i_ready1) begin
      o_valid1 <= 1'b0;
    end
  end

  // Accept counters: clear wins over increment, natural wrap at full scale
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt0 <= '0;
      o_cnt1 <= '0;
    end else if (i_clr) begin
      o_cnt0 <= '0;
      o_cnt1 <= '0;
    end else begin
      if (acc0) o_cnt0 <= o_cnt0 + 1'b1;
      if (acc1) o_cnt1 <= o_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed bench for demux2_stream with per-sink scoreboards.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. The monitor pops an expected word whenever a sink handshakes.
module tb_demux2_stream;
  localparam int W  = 32;
  localparam int CW = 8;

  logic          i_clk;
  logic          i_rst_n;
  logic [W-1:0]  i_data;
  logic          i_valid;
  logic          i_sel;
  logic          o_ready;
  logic [W-1:0]  o_d0;
  logic          o_valid0;
  logic          i_ready0;
  logic [W-1:0]  o_d1;
  logic          o_valid1;
  logic          i_ready1;
  logic          i_clr;
  logic [CW-1:0] o_cnt0;
  logic [CW-1:0] o_cnt1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  demux2_stream #(.P_WIDTH(W), .P_CNT_WIDTH(CW)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_sel    (i_sel),
    .o_ready  (o_ready),
    .o_d0     (o_d0),
    .o_valid0 (o_valid0),
    .i_ready0 (i_ready0),
    .o_d1     (o_d1),
    .o_valid1 (o_valid1),
    .i_ready1 (i_ready1),
    .i_clr    (i_clr),
    .o_cnt0   (o_cnt0),
    .o_cnt1   (o_cnt1)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid0 && i_ready0) begin
        if (exp0_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sink0_unexpected: got %h expected nothing", o_d0);
        end else begin
          check("sink0_data", o_d0, exp0_q.pop_front());
        end
      end
      if (o_valid1 && i_ready1) begin
        if (exp1_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sink1_unexpected: got %h expected nothing", o_d1);
        end else begin
          check("sink1_data", o_d1, exp1_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one word and waits (bounded) for the accept edge; returns cycles used.
  task automatic send(input logic sel, input logic [W-1:0] data, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    i_valid = 1'b1;
    i_sel   = sel;
    i_data  = data;
    while (!done && cycles < 50) begin
      @(negedge i_clk);
      if (o_ready) begin
        if (sel) exp1_q.push_back(data);
        else     exp0_q.push_back(data);
        done = 1'b1;
      end
      @(posedge i_clk); #1;
      cycles++;
    end
    i_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    @(posedge i_clk); #1;
    i_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int sum;
    i_rst_n  = 1'b0;
    i_data   = '0;
    i_valid  = 1'b0;
    i_sel    = 1'b0;
    i_ready0 = 1'b1;
    i_ready1 = 1'b1;
    i_clr    = 1'b0;

    // Reset state
    @(negedge i_clk);
    check("rst_valid0", W'(o_valid0), 0);
    check("rst_valid1", W'(o_valid1), 0);
    check("rst_d0", o_d0, 0);
    check("rst_d1", o_d1, 0);
    check("rst_cnt0", W'(o_cnt0), 0);
    check("rst_cnt1", W'(o_cnt1), 0);
    check("rst_ready_sel0", W'(o_ready), 1);
    i_sel = 1'b1; #1;
    check("rst_ready_sel1", W'(o_ready), 1);
    i_sel = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    idle(1);

    // 1: single word to sink 0
    send(1'b0, 32'hAAAAAAAA, cyc);
    @(negedge i_clk);
    check("t1_valid0", W'(o_valid0), 1);
    check("t1_d0", o_d0, 32'hAAAAAAAA);
    check("t1_valid1", W'(o_valid1), 0);
    check("t1_cnt0", W'(o_cnt0), 1);
    check("t1_cnt1", W'(o_cnt1), 0);
    @(posedge i_clk); #1;

    // 2: backpressure on sink 1
    i_ready1 = 1'b0;
    send(1'b1, 32'h55555555, cyc);
    i_sel = 1'b1;
    @(negedge i_clk);
    check("t2_ready_novalid", W'(o_ready), 0);
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_data  = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      check("t2_stall_ready", W'(o_ready), 0);
      check("t2_stall_d1", o_d1, 32'h55555555);
      check("t2_stall_valid1", W'(o_valid1), 1);
      @(posedge i_clk); #1;
    end
    i_ready1 = 1'b1;
    @(negedge i_clk);
    check("t2_release_ready", W'(o_ready), 1);
    exp1_q.push_back(32'h12345678);
    @(posedge i_clk); #1;
    i_valid  = 1'b0;
    i_ready1 = 1'b0;
    @(negedge i_clk);
    check("t2_d1", o_d1, 32'h12345678);
    check("t2_valid1", W'(o_valid1), 1);
    check("t2_cnt1", W'(o_cnt1), 2);
    @(posedge i_clk); #1;

    // 3: cross-steer to sink 0 while sink 1 is stalled full
    i_valid = 1'b1;
    i_sel   = 1'b0;
    i_data  = 32'h87654321;
    @(negedge i_clk);
    check("t3_ready", W'(o_ready), 1);
    exp0_q.push_back(32'h87654321);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("t3_valid0", W'(o_valid0), 1);
    check("t3_d0", o_d0, 32'h87654321);
    check("t3_valid1", W'(o_valid1), 1);
    check("t3_d1", o_d1, 32'h12345678);
    check("t3_cnt0", W'(o_cnt0), 2);
    @(posedge i_clk); #1;
    i_ready1 = 1'b1;
    idle(2);

    // 4: streaming, alternating select, both sinks always ready
    pulse_clr();
    @(negedge i_clk);
    check("t4_clr_cnt0", W'(o_cnt0), 0);
    check("t4_clr_cnt1", W'(o_cnt1), 0);
    @(posedge i_clk); #1;
    sum = 0;
    for (int k = 0; k < 16; k++) begin
      send(k[0], W'(k), cyc);
      sum += cyc;
    end
    check("t4_cycles", W'(sum), 16);
    idle(2);
    @(negedge i_clk);
    check("t4_cnt0", W'(o_cnt0), 8);
    check("t4_cnt1", W'(o_cnt1), 8);
    check("t4_q0_empty", W'(exp0_q.size()), 0);
    check("t4_q1_empty", W'(exp1_q.size()), 0);
    @(posedge i_clk); #1;

    // 5: wrap on sink 0 counter, then clear together with an accept
    pulse_clr();
    for (int k = 0; k < 255; k++) send(1'b0, W'(k) ^ 32'hF0F0_0000, cyc);
    @(negedge i_clk);
    check("t5_cnt0_255", W'(o_cnt0), 255);
    @(posedge i_clk); #1;
    send(1'b0, 32'h0000_BEEF, cyc);
    @(negedge i_clk);
    check("t5_cnt0_wrap", W'(o_cnt0), 0);
    @(posedge i_clk); #1;
    send(1'b1, 32'h0000_0001, cyc);
    send(1'b0, 32'h0000_0002, cyc);
    @(negedge i_clk);
    check("t5_cnt0_one", W'(o_cnt0), 1);
    check("t5_cnt1_one", W'(o_cnt1), 1);
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_sel   = 1'b0;
    i_data  = 32'hDEAD_0001;
    i_clr   = 1'b1;
    @(negedge i_clk);
    check("t5_clr_ready", W'(o_ready), 1);
    exp0_q.push_back(32'hDEAD_0001);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_clr   = 1'b0;
    @(negedge i_clk);
    check("t5_clr_cnt0", W'(o_cnt0), 0);
    check("t5_clr_cnt1", W'(o_cnt1), 0);
    check("t5_clr_d0", o_d0, 32'hDEAD_0001);
    check("t5_clr_valid0", W'(o_valid0), 1);
    @(posedge i_clk); #1;

    // 6: asynchronous reset with sink 1 stalled full
    send(1'b0, 32'h0000_0011, cyc);
    i_ready1 = 1'b0;
    send(1'b1, 32'hCAFE_F00D, cyc);
    @(negedge i_clk);
    check("t6_pre_valid1", W'(o_valid1), 1);
    check("t6_pre_cnt0", W'(o_cnt0), 1);
    check("t6_pre_cnt1", W'(o_cnt1), 1);
    #2;
    i_rst_n = 1'b0;
    exp1_q.delete();
    #1;
    check("t6_valid1", W'(o_valid1), 0);
    check("t6_cnt0", W'(o_cnt0), 0);
    check("t6_cnt1", W'(o_cnt1), 0);
    check("t6_d1", o_d1, 0);
    @(posedge i_clk); #1;
    i_rst_n  = 1'b1;
    i_ready1 = 1'b1;
    send(1'b1, 32'h0000_600D, cyc);
    @(negedge i_clk);
    check("t6_resume_valid1", W'(o_valid1), 1);
    check("t6_resume_d1", o_d1, 32'h0000_600D);
    check("t6_resume_cnt1", W'(o_cnt1), 1);
    check("t6_resume_cnt0", W'(o_cnt0), 0);
    @(posedge i_clk); #1;
    idle(3);

    // Final report
    check("end_q0_empty", W'(exp0_q.size()), 0);
    check("end_q1_empty", W'(exp1_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
